// File: rtl/pwm_capture_pkg.sv
// Shared types and constants for the PWM input capture block.
package pwm_capture_pkg;

  localparam int CNT_W_DEF = 16;
  localparam logic [CNT_W_DEF-1:0] CNT_MAX = '1;

  typedef enum logic [1:0] {
    IDLE,
    SEEK,
    HIGH,
    LOW
  } cap_state_e;

endpackage

// File: rtl/pwm_in_filter.sv
// Synchroniser, glitch filter and edge strobes for the asynchronous PWM input.
module pwm_in_filter #(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3
) (
  input  logic clk,
  input  logic rst,
  input  logic pwm_in,
  output logic level,
  output logic rise,
  output logic fall
);

  localparam int RUN_W = $clog2(FILT_LEN + 1);

  logic [SYNC_STAGES-1:0] sync_q;
  logic [RUN_W-1:0]       run_cnt;
  logic                   level_d;
  logic                   sample;

  assign sample = sync_q[SYNC_STAGES-1];

  // NOTE: sequential state is assigned with <= only, so every flop samples
  // the pre-edge value of its neighbours and the shift chain cannot collapse.
  always_ff @(posedge clk) begin
    if (rst) begin
      sync_q  <= '0;
      run_cnt <= '0;
      level   <= 1'b0;
      level_d <= 1'b0;
    end else begin
      sync_q  <= {sync_q[SYNC_STAGES-2:0], pwm_in};
      level_d <= level;
      // run_cnt counts consecutive samples disagreeing with the accepted level
      if (sample == level) begin
        run_cnt <= '0;
      end else if (run_cnt == RUN_W'(FILT_LEN - 1)) begin
        level   <= sample;
        run_cnt <= '0;
      end else begin
        run_cnt <= run_cnt + 1'b1;
      end
    end
  end

  assign rise = level & ~level_d;
  assign fall = ~level & level_d;

endmodule

// File: rtl/pwm_capture.sv
// PWM input capture: measures period and high time of pwm_in in clk cycles.
module pwm_capture
  import pwm_capture_pkg::*;
#(
  parameter int SYNC_STAGES = 2,
  parameter int FILT_LEN    = 3,
  parameter int CNT_W       = CNT_W_DEF
) (
  input  logic             clk,
  input  logic             rst,
  input  logic             cap_en,
  input  logic             pwm_in,
  input  logic             clr_flags,
  output logic [CNT_W-1:0] period_out,
  output logic [CNT_W-1:0] high_out,
  output logic             meas_valid,
  output logic             level,
  output logic             overflow
);

  localparam logic [CNT_W-1:0] SAT = '1;

  cap_state_e       state, state_n;
  logic [CNT_W-1:0] cnt, cnt_n;
  logic [CNT_W-1:0] hi_lat, hi_lat_n;
  logic             rise, fall;
  logic             close_period;
  logic             sat;

  pwm_in_filter #(
    .SYNC_STAGES(SYNC_STAGES),
    .FILT_LEN   (FILT_LEN)
  ) u_filter (
    .clk   (clk),
    .rst   (rst),
    .pwm_in(pwm_in),
    .level (level),
    .rise  (rise),
    .fall  (fall)
  );

  // NOTE: every signal written here gets a default first; a missed branch
  // would otherwise hold its value and infer a latch.
  always_comb begin
    state_n      = state;
    cnt_n        = cnt;
    hi_lat_n     = hi_lat;
    close_period = 1'b0;
    sat          = 1'b0;
    if (!cap_en) begin
      state_n = IDLE;
      cnt_n   = '0;
    end else begin
      unique case (state)
        IDLE: begin
          cnt_n   = '0;
          state_n = SEEK;
        end
        SEEK: begin
          if (rise) begin
            cnt_n   = CNT_W'(1);
            state_n = HIGH;
          end
        end
        HIGH: begin
          if (fall) begin
            hi_lat_n = cnt;
            state_n  = LOW;
            cnt_n    = (cnt == SAT) ? cnt : cnt + 1'b1;
          end else if (cnt == SAT) begin
            sat = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        LOW: begin
          if (rise) begin
            close_period = 1'b1;
            cnt_n        = CNT_W'(1);
            state_n      = HIGH;
          end else if (cnt == SAT) begin
            sat = 1'b1;
          end else begin
            cnt_n = cnt + 1'b1;
          end
        end
        default: state_n = IDLE;
      endcase
      // a stuck line abandons the measurement and waits for a fresh rise
      if (sat) begin
        state_n = SEEK;
        cnt_n   = '0;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state      <= IDLE;
      cnt        <= '0;
      hi_lat     <= '0;
      period_out <= '0;
      high_out   <= '0;
      meas_valid <= 1'b0;
      overflow   <= 1'b0;
    end else begin
      state      <= state_n;
      cnt        <= cnt_n;
      hi_lat     <= hi_lat_n;
      meas_valid <= close_period;
      if (close_period) begin
        period_out <= cnt;
        high_out   <= hi_lat;
      end
      if (sat) begin
        overflow <= 1'b1;
      end else if (clr_flags) begin
        overflow <= 1'b0;
      end
    end
  end

endmodule

// File: tb/tb_pwm_capture.sv
// Scoreboard bench for pwm_capture: a default instance and a FILT_LEN=1, 8-bit one.
module tb_pwm_capture;
  import pwm_capture_pkg::*;

  typedef struct {
    int p;
    int h;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;

  // default instance
  logic        cap_en = 1'b0, pwm_in = 1'b0, clr_flags = 1'b0;
  logic [15:0] period_out, high_out;
  logic        meas_valid, level, overflow;

  // minimum-waveform / short-counter instance
  logic        s_cap_en = 1'b0, s_pwm = 1'b0, s_clr = 1'b0;
  logic [7:0]  s_period, s_high;
  logic        s_mv, s_level, s_ovf;

  int   total = 0;
  int   bad   = 0;
  exp_t q0[$];
  exp_t q1[$];
  bit   have_prev[2];
  int   prev_p[2];
  int   prev_h[2];
  int   mv_cnt = 0, s_mv_cnt = 0;
  int   rise_cnt = 0, fall_cnt = 0;
  logic lvl_prev = 1'b0;

  pwm_capture u_dut (
    .clk       (clk),
    .rst       (rst),
    .cap_en    (cap_en),
    .pwm_in    (pwm_in),
    .clr_flags (clr_flags),
    .period_out(period_out),
    .high_out  (high_out),
    .meas_valid(meas_valid),
    .level     (level),
    .overflow  (overflow)
  );

  pwm_capture #(.SYNC_STAGES(2), .FILT_LEN(1), .CNT_W(8)) u_small (
    .clk       (clk),
    .rst       (rst),
    .cap_en    (s_cap_en),
    .pwm_in    (s_pwm),
    .clr_flags (s_clr),
    .period_out(s_period),
    .high_out  (s_high),
    .meas_valid(s_mv),
    .level     (s_level),
    .overflow  (s_ovf)
  );

  always #5 clk = ~clk;

  task automatic check(input string tag, input logic [31:0] got, input logic [31:0] exp);
    total++;
    if (got !== exp) begin
      bad++;
      $display("FAIL %s: got=%0d expected=%0d at %0t", tag, got, exp, $time);
    end
  endtask

  task automatic push(input bit sel, input int p, input int h);
    exp_t e;
    e.p = p;
    e.h = h;
    if (sel) q1.push_back(e);
    else     q0.push_back(e);
  endtask

  task automatic drive(input bit sel, input logic v, input int n);
    if (sel) s_pwm = v;
    else     pwm_in = v;
    repeat (n) @(negedge clk);
  endtask

  // each rise closes the previous period, so its expectation is queued here
  task automatic run_wave(input bit sel, input int hi, input int lo, input int n);
    for (int i = 0; i < n; i++) begin
      if (have_prev[sel]) push(sel, prev_p[sel], prev_h[sel]);
      drive(sel, 1'b1, hi);
      drive(sel, 1'b0, lo);
      prev_p[sel]    = hi + lo;
      prev_h[sel]    = hi;
      have_prev[sel] = 1'b1;
    end
  endtask

  task automatic close_period(input bit sel, input int hi);
    if (have_prev[sel]) push(sel, prev_p[sel], prev_h[sel]);
    drive(sel, 1'b1, hi);
    have_prev[sel] = 1'b0;
  endtask

  // wait for a filtered level of 1, then count cycles until overflow shows
  task automatic time_overflow(input bit sel, input int budget, output int k);
    int n;
    n = 0;
    while (!(sel ? s_level : level) && n < 20) begin
      @(negedge clk);
      n++;
    end
    if (n >= 20) check(sel ? "s_level_timeout" : "level_timeout", 0, 1);
    k = 0;
    while (!(sel ? s_ovf : overflow) && k < budget) begin
      @(negedge clk);
      k++;
    end
  endtask

  always @(negedge clk) begin
    if (!rst && meas_valid) begin
      mv_cnt++;
      if (q0.size() == 0) begin
        check("mv_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q0.pop_front();
        check("period", period_out, e.p);
        check("high", high_out, e.h);
      end
    end
    if (!rst && s_mv) begin
      s_mv_cnt++;
      if (q1.size() == 0) begin
        check("s_mv_unexpected", 1, 0);
      end else begin
        exp_t e;
        e = q1.pop_front();
        check("s_period", s_period, e.p);
        check("s_high", s_high, e.h);
      end
    end
    if (level && !lvl_prev) rise_cnt++;
    if (!level && lvl_prev) fall_cnt++;
    lvl_prev = level;
  end

  initial begin
    #2_000_000;
    $display("FAIL watchdog: got=timeout expected=finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int r0, f0, mv0, k;
    @(negedge clk);

    // reset with a toggling input
    rst = 1'b1;
    for (int i = 0; i < 3; i++) begin
      pwm_in = 1'(i % 2 == 0);
      s_pwm  = 1'(i % 2 == 0);
      @(negedge clk);
    end
    check("rst_period", period_out, 0);
    check("rst_high", high_out, 0);
    check("rst_mv", meas_valid, 0);
    check("rst_level", level, 0);
    check("rst_ovf", overflow, 0);
    check("rst_state", u_dut.state, IDLE);
    pwm_in = 1'b0;
    s_pwm  = 1'b0;
    rst    = 1'b0;
    drive(0, 1'b0, 10);

    // loopback: 10-cycle period, 4 high
    cap_en = 1'b1;
    drive(0, 1'b0, 3);
    run_wave(0, 4, 6, 6);
    cap_en = 1'b0;
    have_prev[0] = 1'b0;
    repeat (12) @(negedge clk);
    check("loop_drain", q0.size(), 0);
    check("loop_count", mv_cnt, 5);

    // glitch rejection
    r0 = rise_cnt;
    f0 = fall_cnt;
    drive(0, 1'b1, 2);
    drive(0, 1'b0, 10);
    check("glitch_rise", rise_cnt - r0, 0);
    check("glitch_fall", fall_cnt - f0, 0);
    cap_en = 1'b1;
    drive(0, 1'b0, 3);
    run_wave(0, 3, 7, 1);
    check("pulse3_rise", rise_cnt - r0, 1);
    check("pulse3_fall", fall_cnt - f0, 1);
    run_wave(0, 3, 7, 1);

    // enable dropped mid-period, re-enabled while the line is high
    run_wave(0, 4, 6, 3);
    close_period(0, 4);
    drive(0, 1'b0, 3);
    cap_en = 1'b0;
    mv0 = mv_cnt;
    drive(0, 1'b0, 3);
    drive(0, 1'b1, 4);
    drive(0, 1'b0, 6);
    drive(0, 1'b1, 6);
    check("gap_mv", mv_cnt - mv0, 0);
    check("gap_period", period_out, 10);
    check("gap_high", high_out, 4);
    check("gap_state", u_dut.state, IDLE);
    cap_en = 1'b1;
    drive(0, 1'b1, 2);
    drive(0, 1'b0, 6);
    run_wave(0, 4, 6, 3);
    close_period(0, 4);
    drive(0, 1'b0, 6);
    cap_en = 1'b0;
    repeat (4) @(negedge clk);
    check("reen_drain", q0.size(), 0);
    check("reen_count", mv_cnt - mv0, 3);

    // 16-bit saturation: rise cycle plus 65535 counts, flag one edge later
    cap_en = 1'b1;
    drive(0, 1'b0, 8);
    pwm_in = 1'b1;
    time_overflow(0, 70000, k);
    check("ovf_time", k, 65536);
    check("ovf_state", u_dut.state, SEEK);
    check("ovf_hold_period", period_out, 10);
    check("ovf_hold_high", high_out, 4);
    clr_flags = 1'b1;
    @(negedge clk);
    clr_flags = 1'b0;
    check("ovf_clr", overflow, 0);
    cap_en = 1'b0;
    drive(0, 1'b0, 10);

    // minimum waveform on the FILT_LEN=1 instance
    s_cap_en = 1'b1;
    drive(1, 1'b0, 4);
    mv0 = s_mv_cnt;
    run_wave(1, 1, 1, 10);
    drive(1, 1'b0, 8);
    check("min_count", s_mv_cnt - mv0, 9);
    check("min_drain", q1.size(), 0);
    s_cap_en = 1'b0;
    have_prev[1] = 1'b0;
    drive(1, 1'b0, 4);

    // 8-bit saturation, then a clear coinciding with a new saturation
    s_cap_en = 1'b1;
    drive(1, 1'b0, 5);
    s_pwm = 1'b1;
    time_overflow(1, 1000, k);
    check("s_ovf_time", k, 256);
    drive(1, 1'b0, 5);
    s_pwm = 1'b1;
    k = 0;
    while (!s_level && k < 20) begin
      @(negedge clk);
      k++;
    end
    check("s_level_again", s_level, 1);
    repeat (255) @(negedge clk);
    s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    check("s_ovf_set_wins", s_ovf, 1);
    check("s_ovf_state", u_small.state, SEEK);
    s_clr = 1'b1;
    @(negedge clk);
    s_clr = 1'b0;
    check("s_ovf_clr", s_ovf, 0);
    s_cap_en = 1'b0;
    repeat (4) @(negedge clk);
    check("s_end_drain", q1.size(), 0);

    $display("test done: total=%0d bad=%0d", total, bad);
    $finish;
  end

endmodule
